// File: rtl/sram_backup_pkg.sv
// Shared types and constants for the save-RAM backup controller.
// Sector geometry and the transfer FSM state encoding live here.
package sram_backup_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadReq,
    StSaveReq,
    StXfer,
    StFinish
  } state_e;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SECTOR_SHIFT = 9;

  // Whole sectors needed to hold i_size bytes, capped at i_max.
  function automatic logic [31:0] calc_sectors(input logic [31:0] i_size,
                                               input logic [31:0] i_max);
    logic [31:0] w_sec;
    w_sec = i_size >> SECTOR_SHIFT;
    if ((i_size & (SECTOR_BYTES - 1)) != 32'd0) begin
      w_sec = w_sec + 32'd1;
    end
    if (w_sec > i_max) begin
      w_sec = i_max;
    end
    return w_sec;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered edge detector: remembers the previous level and flags
// rising and falling transitions in the cycle they are first seen.
module edge_rise (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;
  assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/sram_backup_ctrl.sv
// Sector-by-sector mover between the SD save image and the SDRAM save window,
// with dirty tracking of CPU writes to save RAM.
module sram_backup_ctrl
  import sram_backup_pkg::*;
#(
  parameter int unsigned MAX_SECTORS = 16,
  parameter int unsigned SEC_W       = 9
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_img_mounted,
  input  logic [31:0]                     i_img_size,
  input  logic                            i_downloading,
  input  logic                            i_save_req,
  input  logic                            i_cpu_sram_write,
  output logic [31:0]                     o_sd_lba,
  output logic                            o_sd_rd,
  output logic                            o_sd_wr,
  input  logic                            i_sd_ack,
  input  logic [SECTOR_SHIFT-1:0]         i_sd_buff_addr,
  input  logic                            i_sd_buff_wr,
  input  logic                            i_sd_buff_rd,
  output logic [SEC_W+SECTOR_SHIFT-1:0]   o_ram_addr,
  output logic                            o_ram_req,
  output logic                            o_ram_we,
  output logic                            o_bk_ena,
  output logic                            o_busy,
  output logic                            o_dirty,
  output logic                            o_done
);

  state_e                          r_state;
  logic [31:0]                     r_sd_lba;
  logic [31:0]                     r_sectors;
  logic                            r_sd_rd;
  logic                            r_sd_wr;
  logic                            r_dir_save;
  logic                            r_abort;
  logic                            r_bk_ena;
  logic                            r_dirty;
  logic                            r_done;
  logic [SEC_W+SECTOR_SHIFT-1:0]   r_ram_addr;
  logic                            r_ram_req;
  logic                            r_ram_we;

  logic        w_mnt_rise;
  logic        w_mnt_fall;
  logic        w_save_rise;
  logic        w_save_fall;
  logic        w_ack_rise;
  logic        w_ack_fall;
  logic        w_dl_rise;
  logic        w_dl_fall;
  logic        w_unused;
  logic        w_loading;
  logic        w_last;
  logic [31:0] w_sectors;

  edge_rise u_mnt_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_img_mounted),
    .o_rise  (w_mnt_rise),
    .o_fall  (w_mnt_fall)
  );

  edge_rise u_save_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_save_req),
    .o_rise  (w_save_rise),
    .o_fall  (w_save_fall)
  );

  edge_rise u_ack_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_sd_ack),
    .o_rise  (w_ack_rise),
    .o_fall  (w_ack_fall)
  );

  edge_rise u_dl_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_downloading),
    .o_rise  (w_dl_rise),
    .o_fall  (w_dl_fall)
  );

  assign w_unused  = &{1'b0, w_mnt_fall, w_save_fall, w_dl_fall};
  assign w_sectors = calc_sectors(i_img_size, MAX_SECTORS);
  assign w_last    = ((r_sd_lba + 32'd1) == r_sectors);
  // CPU writes landing while the image is being loaded are overwritten anyway.
  assign w_loading = (r_state == StLoadReq) || ((r_state == StXfer) && !r_dir_save);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_sd_lba   <= 32'd0;
      r_sectors  <= 32'd0;
      r_sd_rd    <= 1'b0;
      r_sd_wr    <= 1'b0;
      r_dir_save <= 1'b0;
      r_abort    <= 1'b0;
      r_bk_ena   <= 1'b0;
      r_dirty    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (i_cpu_sram_write && r_bk_ena && !w_loading) begin
        r_dirty <= 1'b1;
      end

      if (w_dl_rise && (r_state != StIdle)) begin
        r_abort <= 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (w_mnt_rise) begin
            if (w_sectors == 32'd0) begin
              r_bk_ena <= 1'b0;
            end else begin
              r_bk_ena   <= 1'b1;
              r_sectors  <= w_sectors;
              r_dirty    <= 1'b0;
              r_sd_lba   <= 32'd0;
              r_dir_save <= 1'b0;
              r_sd_rd    <= 1'b1;
              r_state    <= StLoadReq;
            end
          end else if (w_save_rise && r_bk_ena) begin
            r_dirty    <= 1'b0;
            r_sd_lba   <= 32'd0;
            r_dir_save <= 1'b1;
            r_sd_wr    <= 1'b1;
            r_state    <= StSaveReq;
          end
        end

        StLoadReq, StSaveReq: begin
          if (w_ack_rise) begin
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_state <= StXfer;
          end
        end

        StXfer: begin
          if (w_ack_fall) begin
            // A pending abort stops after the sector just acknowledged.
            if (w_last || r_abort || w_dl_rise) begin
              r_done  <= 1'b1;
              r_state <= StFinish;
            end else begin
              r_sd_lba <= r_sd_lba + 32'd1;
              if (r_dir_save) begin
                r_sd_wr <= 1'b1;
                r_state <= StSaveReq;
              end else begin
                r_sd_rd <= 1'b1;
                r_state <= StLoadReq;
              end
            end
          end
        end

        StFinish: begin
          r_sd_lba <= 32'd0;
          r_abort  <= 1'b0;
          r_state  <= StIdle;
        end

        default: begin
          r_sd_rd <= 1'b0;
          r_sd_wr <= 1'b0;
          r_state <= StIdle;
        end
      endcase

      if (w_dl_rise) begin
        r_bk_ena <= 1'b0;
        r_dirty  <= 1'b0;
      end
    end
  end

  // Byte strobes are served in any state; write wins when both are high.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ram_addr <= '0;
      r_ram_we   <= 1'b0;
      r_ram_req  <= 1'b0;
    end else if (i_sd_buff_wr || i_sd_buff_rd) begin
      r_ram_addr <= {r_sd_lba[SEC_W-1:0], i_sd_buff_addr};
      r_ram_we   <= i_sd_buff_wr;
      r_ram_req  <= ~r_ram_req;
    end
  end

  assign o_sd_lba   = r_sd_lba;
  assign o_sd_rd    = r_sd_rd;
  assign o_sd_wr    = r_sd_wr;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_req  = r_ram_req;
  assign o_ram_we   = r_ram_we;
  assign o_bk_ena   = r_bk_ena;
  assign o_busy     = (r_state != StIdle);
  assign o_dirty    = r_dirty;
  assign o_done     = r_done;

endmodule
